// File: rtl/pong_sequencer.sv
// pong_sequencer: game-flow controller for the VGA pong datapath.
// Sequences idle, serve countdown, rally, point hold and game-over, owns
// both scores and drives the ball engine's run/reset/direction/step controls.
//
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   frame_tick               one-cycle pulse per frame
//   miss_left, miss_right    one-cycle pulses: ball passed a paddle
//   serve_btn                serve/start button (level)
//   score_reset              clear game (level)
//   speed_msb, speed_lsb     base-speed select, sampled at rally start
//   ball_run, ball_reset     ball engine run / hold-at-centre
//   serve_dir                launch direction, 1 = right
//   ball_step[2:0]           pixels per frame, 1..7
//   score_left/right[3:0]    player scores
//   winner_left/right        game result, valid in OVER
//   state[2:0]               IDLE=0 SERVE=1 RALLY=2 POINT=3 OVER=4
//
// Build option: define PONG_AUTO_SERVE_EN to launch from SERVE as soon as
// the countdown expires; otherwise a serve edge at count 0 is required.
//
// state | meaning
// IDLE  | waiting for a serve edge, ball held at centre
// SERVE | countdown, ball held at centre
// RALLY | ball running, ramping speed
// POINT | ball frozen after a miss, countdown
// OVER  | game finished, winners valid

module pong_sequencer #(
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int WIN_SCORE    = 9,
   parameter int RAMP_FRAMES  = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       miss_left,
   input  logic       miss_right,
   input  logic       serve_btn,
   input  logic       score_reset,
   input  logic       speed_lsb,
   input  logic       speed_msb,
   output logic       ball_run,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [2:0] ball_step,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic       winner_left,
   output logic       winner_right,
   output logic [2:0] state
);

   localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = $clog2(RAMP_FRAMES + 1);

   localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES);
   localparam logic [CW-1:0] POINT_LOAD = CW'(POINT_FRAMES);
   localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_FRAMES - 1);
   localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_RALLY = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] ramp_q, ramp_d;
   logic [2:0]    step_q, step_d;
   logic [3:0]    sl_q, sl_d, sr_q, sr_d;
   logic          dir_q, dir_d;
   logic          run_q, run_d;
   logic          brst_q, brst_d;
   logic          wl_q, wl_d, wr_q, wr_d;
   logic          serve_q;
   logic          serve_edge;
   logic          launch;

   assign serve_edge = serve_btn & ~serve_q;

`ifdef PONG_AUTO_SERVE_EN
   assign launch = 1'b1;
`else
   // An early edge is simply not stored: only an edge seen at count 0 launches.
   assign launch = serve_edge;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ramp_d  = ramp_q;
      step_d  = step_q;
      sl_d    = sl_q;
      sr_d    = sr_q;
      dir_d   = dir_q;

      if (score_reset) begin
         state_d = S_IDLE;
         sl_d    = '0;
         sr_d    = '0;
         cnt_d   = '0;
         ramp_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (serve_edge) begin
                  state_d = S_SERVE;
                  cnt_d   = SERVE_LOAD;
               end
            end
            S_SERVE: begin
               if (cnt_q == '0) begin
                  if (launch) begin
                     state_d = S_RALLY;
                     step_d  = 3'd1 + {1'b0, speed_msb, speed_lsb};
                     ramp_d  = '0;
                  end
               end else if (frame_tick) begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_RALLY: begin
               if (miss_left || miss_right) begin
                  if (miss_right && !miss_left) begin
                     if (sl_q < WIN) sl_d = sl_q + 4'd1;
                     dir_d = 1'b1;
                  end else if (miss_left && !miss_right) begin
                     if (sr_q < WIN) sr_d = sr_q + 4'd1;
                     dir_d = 1'b0;
                  end
                  state_d = S_POINT;
                  cnt_d   = POINT_LOAD;
               end else if (frame_tick) begin
                  if (ramp_q == RAMP_LAST) begin
                     ramp_d = '0;
                     if (step_q != 3'd7) step_d = step_q + 3'd1;
                  end else begin
                     ramp_d = ramp_q + 1'b1;
                  end
               end
            end
            S_POINT: begin
               if (cnt_q == '0) begin
                  if (sl_q >= WIN || sr_q >= WIN) begin
                     state_d = S_OVER;
                  end else begin
                     state_d = S_SERVE;
                     cnt_d   = SERVE_LOAD;
                  end
               end else if (frame_tick) begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_OVER: begin
               if (serve_edge) begin
                  sl_d    = '0;
                  sr_d    = '0;
                  state_d = S_SERVE;
                  cnt_d   = SERVE_LOAD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs are registered from the next state so they line up with it.
      run_d  = (state_d == S_RALLY);
      brst_d = (state_d == S_IDLE) || (state_d == S_SERVE) || (state_d == S_OVER);
      wl_d   = (state_d == S_OVER) && (sl_d >= WIN);
      wr_d   = (state_d == S_OVER) && (sr_d >= WIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ramp_q  <= '0;
         step_q  <= 3'd1;
         sl_q    <= '0;
         sr_q    <= '0;
         dir_q   <= 1'b0;
         run_q   <= 1'b0;
         brst_q  <= 1'b1;
         wl_q    <= 1'b0;
         wr_q    <= 1'b0;
         serve_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ramp_q  <= ramp_d;
         step_q  <= step_d;
         sl_q    <= sl_d;
         sr_q    <= sr_d;
         dir_q   <= dir_d;
         run_q   <= run_d;
         brst_q  <= brst_d;
         wl_q    <= wl_d;
         wr_q    <= wr_d;
         serve_q <= serve_btn;
      end
   end

   assign ball_run     = run_q;
   assign ball_reset   = brst_q;
   assign serve_dir    = dir_q;
   assign ball_step    = step_q;
   assign score_left   = sl_q;
   assign score_right  = sr_q;
   assign winner_left  = wl_q;
   assign winner_right = wr_q;
   assign state        = state_q;

endmodule

// File: doc/pong_sequencer.md
Name: pong_sequencer

Overview:
- Game-flow controller for the VGA pong datapath. Sequences idle, serve countdown, rally, point hold and game-over, and owns both scores.
- Drives the ball engine's run/reset/direction/step controls from frame ticks, miss events and the player buttons.
- Sits in the 25.125 MHz pixel-clock domain, between the button inputs and the ball/paddle/score renderer.

Parameters:
- SERVE_FRAMES, 60: frames of countdown before a serve may launch.
- POINT_FRAMES, 90: frames the ball is frozen after a miss.
- WIN_SCORE, 9: score that ends the game (≤15).
- RAMP_FRAMES, 300: rally frames per +1 ball-step increment.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse per frame, at vsync start.
- miss_left  input  1  one-cycle pulse: ball passed the left paddle.
- miss_right  input  1  one-cycle pulse: ball passed the right paddle.
- serve_btn  input  1  serve/start button, active-high level.
- score_reset  input  1  clear game, active-high level.
- speed_lsb  input  1  base-speed select bit 0.
- speed_msb  input  1  base-speed select bit 1.
- ball_run  output  1  ball engine advances on frame_tick.
- ball_reset  output  1  ball held at centre.
- serve_dir  output  1  launch direction: 1 = right, 0 = left.
- ball_step  output  3  pixels per frame, 1..7.
- score_left  output  4  left player score.
- score_right  output  4  right player score.
- winner_left  output  1  left won; valid in GAMEOVER.
- winner_right  output  1  right won; valid in GAMEOVER.
- state  output  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4 (debug).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE, scores=0, ball_run=0, ball_reset=1, serve_dir=0.
  - ball_step=1, winner_*=0, frame counter=0, ramp counter=0.
  - serve edge register=0.
- All outputs are registered; every response appears 1 cycle after the causing input.
- Priority each cycle: rst > score_reset > state transitions.
- score_reset while high: scores=0, winner_*=0, state=IDLE, ball_reset=1, ball_run=0.
- Serve edge: serve_btn rising edge, detected against a 1-cycle delayed copy. A held button gives exactly one edge.
- IDLE:
  - ball_reset=1, ball_run=0.
  - Serve edge -> SERVE; frame counter = SERVE_FRAMES.
- SERVE:
  - ball_reset=1, ball_run=0.
  - Counter decrements on frame_tick and stops at 0.
  - When counter==0 and a launch condition holds (see Optional Feature) -> RALLY.
  - On entry to RALLY: latch ball_step = 1 + {speed_msb,speed_lsb}, giving 1..4; clear ramp counter.
- RALLY:
  - ball_reset=0, ball_run=1.
  - Ramp counter increments on frame_tick. When it reaches RAMP_FRAMES-1 it wraps to 0 and ball_step increments, saturating at 7.
  - miss_right alone: score_left+1, serve_dir=1, then POINT.
  - miss_left alone: score_right+1, serve_dir=0, then POINT.
  - Both misses in the same cycle: no score change, serve_dir unchanged, then POINT.
  - Counter = POINT_FRAMES on entry to POINT.
  - Misses outside RALLY are ignored.
- POINT:
  - ball_run=0, ball_reset=0 (ball frozen at the miss position).
  - Counter decrements on frame_tick.
  - At 0: if either score ≥ WIN_SCORE -> OVER; else -> SERVE with counter = SERVE_FRAMES.
- OVER:
  - ball_run=0, ball_reset=1.
  - winner_left = (score_left ≥ WIN_SCORE); winner_right likewise.
  - Serve edge clears scores and winners -> SERVE with counter = SERVE_FRAMES.
- Scores saturate at WIN_SCORE and never wrap.
- frame_tick coincident with a state change is consumed by the new state's counter load and does not decrement.
- Speed inputs are sampled only at RALLY entry; changes mid-rally are ignored.
- Illegal state encodings (5-7) -> IDLE on the next cycle.

Optional Feature:
- Macro: PONG_AUTO_SERVE_EN.
- Defined: SERVE launches into RALLY as soon as the counter reaches 0; no button is needed.
- Not defined: SERVE waits at counter 0 for a serve edge. An edge that arrives before the counter expires is discarded and not remembered.
- IDLE and OVER always require a serve edge in both builds.

Test Plan:
- Reset, then serve edge, then 60 frame_ticks -> no RALLY. Without the macro, one more serve edge gives state=2, ball_run=1, ball_reset=0, ball_step=1 with speed bits 00; with the macro, RALLY is entered after frame 60 with no edge.
- Speed bits 11 at RALLY entry, 300×4 frame_ticks -> ball_step steps 4→5→6→7→7 (saturated); flipping speed bits mid-rally has no effect.
- miss_right in RALLY -> score_left=1, serve_dir=1, state=3. After 90 ticks, state=1 and ball_reset=1.
- miss_left and miss_right in the same cycle -> both scores unchanged, state=3.
- Drive left to 9 points -> OVER with winner_left=1, score_left=9. A further miss pulse changes nothing; a serve edge gives scores 0 and state=1.
- score_reset asserted mid-RALLY with score 3-2 -> next cycle scores 0/0, state=0, ball_run=0. rst asserted in POINT -> all reset values next cycle.
